// File: rtl/dmem_responder.sv
// dmem_responder: RV32I byte/half/word data memory with sticky fault capture and an MMIO status/TOHOST window.
// Define DMEM_PERF_CNT_EN to add the CYCLE_CNT (0xC) and STORE_CNT (0x10) MMIO counters.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [2:0]  funct3M,
   output logic [31:0] ReadDataM,
   output logic        err_flag,
   output logic [31:0] err_addr,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic          isMmio, isHalf, isWord, loadLegal, storeLegal, misaligned;
   logic          loadBad, fault, storeOk, wrStatus, wrTohost;
   logic [11:0]   offset;
   logic [AW-1:0] wordIdx;
   logic [31:0]   mmioRd, word, wrData;
   logic [3:0]    laneEn;
   logic [7:0]    rdByte;
   logic [15:0]   rdHalf;
`ifdef DMEM_PERF_CNT_EN
   logic [31:0]   cycleCnt, storeCnt;
`endif

   assign isMmio     = ALUResultM[31:12] == MMIO_BASE[31:12];
   assign offset     = ALUResultM[11:0];
   assign wordIdx    = ALUResultM[AW+1:2];
   assign isHalf     = funct3M[1:0] == 2'b01;
   assign isWord     = funct3M == 3'b010;
   assign loadLegal  = funct3M[1:0] != 2'b11 && funct3M != 3'b110;
   assign storeLegal = !funct3M[2] && funct3M[1:0] != 2'b11;
   assign misaligned = (isHalf && ALUResultM[0]) || (isWord && ALUResultM[1:0] != 2'b00);
   // MMIO registers only accept full-word accesses
   assign loadBad    = !loadLegal || misaligned || (isMmio && !isWord);
   assign fault      = MemWriteM ? (!storeLegal || misaligned || (isMmio && !isWord)) : loadBad;
   assign storeOk    = MemWriteM && !fault;
   assign wrStatus   = storeOk && isMmio && offset == 12'h000;
   assign wrTohost   = storeOk && isMmio && offset == 12'h008;

   always_comb begin
      mmioRd = '0;
      if (offset == 12'h000) mmioRd = {31'b0, err_flag};
      else if (offset == 12'h004) mmioRd = err_addr;
      else if (offset == 12'h008) mmioRd = tohost_data;
`ifdef DMEM_PERF_CNT_EN
      else if (offset == 12'h00C) mmioRd = cycleCnt;
      else if (offset == 12'h010) mmioRd = storeCnt;
`endif
   end

   assign word      = isMmio ? mmioRd : mem[wordIdx];
   assign rdByte    = word[{ALUResultM[1:0], 3'b000} +: 8];
   assign rdHalf    = ALUResultM[1] ? word[31:16] : word[15:0];
   assign ReadDataM = loadBad ? '0 :
                      isWord  ? word :
                      isHalf  ? {{16{!funct3M[2] && rdHalf[15]}}, rdHalf} :
                                {{24{!funct3M[2] && rdByte[7]}}, rdByte};

   assign laneEn = isWord ? 4'hF : isHalf ? (ALUResultM[1] ? 4'hC : 4'h3) : 4'b0001 << ALUResultM[1:0];
   assign wrData = isWord ? WriteDataM : isHalf ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};

   always_ff @(posedge clk)
      if (!reset && storeOk && !isMmio)
         for (int i = 0; i < 4; i++)
            if (laneEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];

   always_ff @(posedge clk)
      if (reset) begin
         err_flag     <= 1'b0;
         err_addr     <= '0;
         tohost_valid <= 1'b0;
         tohost_data  <= '0;
      end else begin
         tohost_valid <= wrTohost;
         if (wrTohost) tohost_data <= WriteDataM;
         if (fault) begin
            err_flag <= 1'b1;
            if (!err_flag) err_addr <= ALUResultM;
         end else if (wrStatus) begin
            err_flag <= 1'b0;
            err_addr <= '0;
         end
      end

`ifdef DMEM_PERF_CNT_EN
   always_ff @(posedge clk)
      if (reset) begin
         cycleCnt <= '0;
         storeCnt <= '0;
      end else begin
         cycleCnt <= cycleCnt + 32'd1;
         if (storeOk) storeCnt <= storeCnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against a byte-array reference model.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWriteM = 1'b0;
   logic [31:0] ALUResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic [2:0]  funct3M = 3'b010;
   logic [31:0] ReadDataM, err_addr, tohost_data;
   logic        err_flag, tohost_valid;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ramB [256];
   bit          known [256];
   logic        mErrFlag = 1'b0;
   logic [31:0] mErrAddr = '0;
   logic [31:0] mTohost = '0;
   logic        mTohostValid = 1'b0;
   logic [31:0] mCycles = '0;
   logic [31:0] mStores = '0;

   dmem_responder dut (
      .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .funct3M(funct3M), .ReadDataM(ReadDataM),
      .err_flag(err_flag), .err_addr(err_addr), .tohost_valid(tohost_valid), .tohost_data(tohost_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int sizeOf(logic [2:0] f3);
      return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
   endfunction

   function automatic bit isMmio(logic [31:0] a);
      return a[31:12] == 20'h00001;
   endfunction

   function automatic bit faulty(bit we, logic [31:0] a, logic [2:0] f3);
      bit legal;
      int sz;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz = sizeOf(f3);
      return !legal || (a % sz != 0) || (isMmio(a) && sz != 4);
   endfunction

   function automatic logic [31:0] mmioRead(logic [11:0] off);
      case (off)
         12'h000: return {31'b0, mErrFlag};
         12'h004: return mErrAddr;
         12'h008: return mTohost;
`ifdef DMEM_PERF_CNT_EN
         12'h00C: return mCycles;
         12'h010: return mStores;
`endif
         default: return '0;
      endcase
   endfunction

   function automatic logic [31:0] modelLoad(logic [31:0] a, logic [2:0] f3, output bit ok);
      int sz;
      int b;
      logic [31:0] v;
      sz = sizeOf(f3);
      v = '0;
      ok = 1'b1;
      if (faulty(1'b0, a, f3)) return '0;
      if (isMmio(a)) return mmioRead(a[11:0]);
      for (int k = 0; k < sz; k++) begin
         b = (int'(a[7:0]) + k) % 256;
         ok = ok && known[b];
         v = v | (32'(ramB[b]) << (8 * k));
      end
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      return v;
   endfunction

   task automatic modelEdge(bit rst, bit we, logic [31:0] a, logic [31:0] d, logic [2:0] f3);
      bit flt;
      bit st;
      int b;
      if (rst) begin
         mErrFlag = 0; mErrAddr = 0; mTohost = 0; mTohostValid = 0; mCycles = 0; mStores = 0;
         return;
      end
      mCycles++;
      flt = faulty(we, a, f3);
      st = we && !flt;
      mTohostValid = st && isMmio(a) && a[11:0] == 12'h008;
      if (flt) begin
         if (!mErrFlag) mErrAddr = a;
         mErrFlag = 1'b1;
      end
      if (st) begin
         mStores++;
         if (isMmio(a)) begin
            if (a[11:0] == 12'h000) begin mErrFlag = 0; mErrAddr = 0; end
            if (a[11:0] == 12'h008) mTohost = d;
         end else
            for (int k = 0; k < sizeOf(f3); k++) begin
               b = (int'(a[7:0]) + k) % 256;
               ramB[b] = d[8*k +: 8];
               known[b] = 1'b1;
            end
      end
   endtask

   task automatic checkRegs(string tag);
      check({tag, ".err_flag"}, 32'(err_flag), 32'(mErrFlag));
      check({tag, ".err_addr"}, err_addr, mErrAddr);
      check({tag, ".tohost_valid"}, 32'(tohost_valid), 32'(mTohostValid));
      check({tag, ".tohost_data"}, tohost_data, mTohost);
   endtask

   task automatic access(bit we, logic [31:0] a, logic [31:0] d, logic [2:0] f3);
      logic [31:0] exp;
      bit ok;
      MemWriteM = we; ALUResultM = a; WriteDataM = d; funct3M = f3;
      #1;
      exp = modelLoad(a, f3, ok);
      if (ok) check("ReadDataM", ReadDataM, exp);
      @(posedge clk);
      modelEdge(1'b0, we, a, d, f3);
      #1;
      checkRegs("acc");
   endtask

   task automatic expectLoad(string tag, logic [31:0] a, logic [2:0] f3, logic [31:0] exp);
      access(1'b0, a, '0, f3);
      check(tag, ReadDataM, exp);
   endtask

   task automatic doReset(bit we, logic [31:0] a, logic [31:0] d, logic [2:0] f3);
      MemWriteM = we; ALUResultM = a; WriteDataM = d; funct3M = f3;
      reset = 1'b1;
      @(posedge clk);
      modelEdge(1'b1, we, a, d, f3);
      #1;
      reset = 1'b0;
      checkRegs("reset");
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0] f3;
      bit we;
      doReset(1'b0, '0, '0, 3'b010);
      for (int i = 0; i < 64; i++) access(1'b1, 32'(i * 4), $urandom, 3'b010);

      access(1'b1, 32'h20, 32'h11223344, 3'b010);
      access(1'b1, 32'h21, 32'h000000AB, 3'b000);
      access(1'b1, 32'h22, 32'h0000BEEF, 3'b001);
      expectLoad("lane_merge", 32'h20, 3'b010, 32'hBEEFAB44);

      access(1'b1, 32'h24, 32'h800080F0, 3'b010);
      expectLoad("lb_sext", 32'h24, 3'b000, 32'hFFFFFFF0);
      expectLoad("lbu_zext", 32'h24, 3'b100, 32'h000000F0);
      expectLoad("lh_sext", 32'h26, 3'b001, 32'hFFFF8000);
      expectLoad("lhu_zext", 32'h26, 3'b101, 32'h00008000);

      access(1'b1, 32'h1000, '0, 3'b010);
      access(1'b1, 32'h31, 32'hDEADBEEF, 3'b010);
      check("mis_flag", 32'(err_flag), 32'd1);
      check("mis_addr", err_addr, 32'h31);
      access(1'b0, 32'h30, '0, 3'b010);
      access(1'b0, 32'h45, '0, 3'b001);
      check("first_fault_kept", err_addr, 32'h31);
      access(1'b1, 32'h1000, '0, 3'b010);
      check("clr_flag", 32'(err_flag), 32'd0);
      check("clr_addr", err_addr, 32'h0);

      access(1'b1, 32'h40, 32'h12345678, 3'b011);
      check("ill_flag", 32'(err_flag), 32'd1);
      check("ill_addr", err_addr, 32'h40);
      expectLoad("ill_load_zero", 32'h40, 3'b110, 32'h0);
      access(1'b1, 32'h1000, '0, 3'b010);

      access(1'b1, 32'h1008, 32'h1, 3'b010);
      check("tohost_pulse", 32'(tohost_valid), 32'd1);
      check("tohost_data", tohost_data, 32'h1);
      access(1'b0, '0, '0, 3'b010);
      check("tohost_single", 32'(tohost_valid), 32'd0);
      access(1'b1, 32'h1008, 32'hA5, 3'b010);
      check("b2b_first", tohost_data, 32'hA5);
      access(1'b1, 32'h1008, 32'h5A, 3'b010);
      check("b2b_valid", 32'(tohost_valid), 32'd1);
      check("b2b_second", tohost_data, 32'h5A);

      access(1'b0, 32'h22, '0, 3'b010);
      doReset(1'b1, 32'h20, 32'hFFFFFFFF, 3'b010);
      check("rst_tohost", tohost_data, 32'h0);
      check("rst_err", 32'(err_flag), 32'd0);
      expectLoad("ram_retained", 32'h20, 3'b010, 32'hBEEFAB44);

      doReset(1'b0, '0, '0, 3'b010);
      repeat (10) access(1'b0, '0, '0, 3'b010);
      access(1'b1, 32'h50, 32'h1, 3'b010);
      access(1'b1, 32'h54, 32'h2, 3'b010);
      access(1'b1, 32'h58, 32'h3, 3'b010);
`ifdef DMEM_PERF_CNT_EN
      MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h1010;
      #1 check("store_cnt", ReadDataM, 32'd3);
      ALUResultM = 32'h100C;
      #1 check("cycle_cnt", ReadDataM, 32'd13);
      @(posedge clk);
      modelEdge(1'b0, 1'b0, 32'h100C, '0, 3'b010);
      #1;
`else
      expectLoad("no_cycle_cnt", 32'h100C, 3'b010, 32'h0);
      expectLoad("no_store_cnt", 32'h1010, 3'b010, 32'h0);
`endif

      repeat (600) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'b010;
         if ($urandom_range(0, 9) < 7) a = 32'($urandom_range(0, 255)) | ($urandom & 32'hFFFF_E000);
         else a = 32'h1000 + 32'(4 * $urandom_range(0, 5)) + ($urandom_range(0, 4) == 0 ? 32'($urandom_range(0, 3)) : 32'd0);
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         if ($urandom_range(0, 79) == 0) doReset(we, a, $urandom, f3);
         else access(we, a, $urandom, f3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's memory-stage port: MemWriteM, ALUResultM, WriteDataM and funct3M in; ReadDataM out.
- Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW over a word-organised RAM.
- Detects misaligned and illegal accesses and latches them in a sticky error register.
- Exposes a small MMIO window: error status and a TOHOST mailbox used by simulation benches to end a program run.

Parameters:
- DEPTH_WORDS, 64: RAM size in 32-bit words; power of two, at least 4.
- MMIO_BASE, 32'h0000_1000: base of the 4 KiB MMIO window; bits [11:0] must be zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWriteM  in  1  store strobe for the current memory-stage access.
- ALUResultM  in  32  byte address of the access.
- WriteDataM  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- funct3M  in  3  access size and sign, per RV32I load/store funct3 encoding.
- ReadDataM  out  32  load data, combinational, valid in the same cycle.
- err_flag  out  1  sticky error indicator.
- err_addr  out  32  address of the first faulting access since the last clear.
- tohost_valid  out  1  one-cycle pulse after a word store to TOHOST.
- tohost_data  out  32  last value written to TOHOST.

Behaviour:
- Decode: MMIO when ALUResultM[31:12] == MMIO_BASE[31:12]; otherwise RAM.
  - RAM word index is ALUResultM[AW+1:2], with AW = clog2(DEPTH_WORDS).
  - Upper address bits alias.
- Loads are combinational and always driven from the current array or register contents, independent of MemWriteM.
  - funct3 000 (LB): byte at addr[1:0], sign-extended.
  - funct3 100 (LBU): same byte, zero-extended.
  - funct3 001 (LH): half at addr[1], sign-extended.
  - funct3 101 (LHU): same half, zero-extended.
  - funct3 010 (LW): full word.
  - funct3 011, 110, 111: ReadDataM = 0 and the access is illegal.
- Stores: committed at the rising edge when MemWriteM = 1.
  - SB writes one byte lane selected by addr[1:0].
  - SH writes two lanes selected by addr[1].
  - SW writes all four lanes.
  - Other funct3 values with MemWriteM = 1 are illegal; no write occurs.
- A load in the same cycle as a store to the same word returns the pre-store contents.
- Misaligned access:
  - Condition: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Loads return 0; stores are suppressed.
- Error capture:
  - Every misaligned or illegal access sets err_flag on the next edge.
  - err_addr is loaded only when err_flag was 0, so it holds the first fault.
  - Later faults leave err_addr unchanged.
- Error signalling for loads: the core has no read strobe, so err_flag and err_addr only flag load misalignment/illegality while MemWriteM = 0 and a load instruction is in the memory stage. The bench qualifies these with the instruction stream.
- MMIO registers (word access only; byte/half access to MMIO is illegal):
  - Offset 0x0 ERR_STATUS: read returns {31'b0, err_flag}. Any SW clears err_flag and err_addr at the edge.
  - Offset 0x4 ERR_ADDR: read-only; writes are ignored with no error.
  - Offset 0x8 TOHOST: SW loads tohost_data and drives tohost_valid = 1 for exactly the next cycle. Reads return tohost_data.
  - Back-to-back TOHOST stores give back-to-back pulses, each carrying the newer data.
  - Unmapped offsets: reads return 0; writes are ignored with no error.
- Reset (synchronous, clk edge with reset = 1):
  - Clears err_flag, err_addr, tohost_valid, tohost_data and the optional counters.
  - RAM contents are not cleared.
  - A store presented in the reset cycle is discarded.
  - ReadDataM stays combinational through reset.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined: adds two 32-bit wrapping MMIO counters.
  - CYCLE_CNT at offset 0xC: increments every non-reset cycle.
  - STORE_CNT at offset 0x10: increments on each committed, non-suppressed store, RAM or MMIO.
  - Both are read-only; writes are ignored with no error; both clear on reset.
- Not defined: offsets 0xC and 0x10 behave as unmapped (read 0), and no counter flops are built.

Test Plan:
- Byte/half lanes: SW 0x11223344 to 0x20; SB 0xAB to 0x21; SH 0xBEEF to 0x22 -> LW 0x20 = 0xBEEFAB44.
- Sign extension: with word 0x8000_80F0 at 0x24:
  - LB 0x24 = 0xFFFFFFF0; LBU 0x24 = 0x000000F0.
  - LH 0x26 = 0xFFFF8000; LHU 0x26 = 0x00008000.
- Misaligned store: SW 0xDEADBEEF to 0x31 -> word 0x30 unchanged; err_flag = 1 next cycle; err_addr = 0x31.
  - A second fault at 0x45 leaves err_addr = 0x31.
  - SW to 0x1000 clears both.
- Illegal funct3: MemWriteM = 1 with funct3 011 at 0x40 -> no write; err_flag = 1, err_addr = 0x40.
  - Load with funct3 110 -> ReadDataM = 0.
- TOHOST: SW 0x1 to 0x1008 -> tohost_valid high exactly one cycle and tohost_data = 0x1.
  - Reset asserted mid-run clears tohost_data and err_flag; RAM word 0x20 is retained.
- With DMEM_PERF_CNT_EN: after reset, 10 idle cycles then 3 valid stores -> STORE_CNT = 3 and CYCLE_CNT equals the elapsed non-reset cycles.
  - Without the macro: LW 0x100C = 0.
